// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I ALU op codes, opcodes, funct7 values and funct3-to-ALU-op mapping
package rv32i_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  function automatic logic [3:0] f3_aluop(input logic [2:0] f3);
    return f3 == 3'b000 ? ALU_ADD :
           f3 == 3'b001 ? ALU_SLL :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b011 ? ALU_SLTU :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b101 ? ALU_SRL :
           f3 == 3'b110 ? ALU_OR : ALU_AND;
  endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: I-type (sign-extended) and U-type immediates from instruction bits [31:12]
//   upper  in  20  in_instr[31:12]
//   imm_i  out 32  sign-extended instr[31:20]
//   imm_u  out 32  {instr[31:12], 12'b0}
module imm_gen (
  input  logic [19:0] upper,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u
);
  assign imm_i = {{20{upper[19]}}, upper[19:8]};
  assign imm_u = {upper, 12'b0};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I OP/OP-IMM/LUI/AUIPC decoder with a valid/ready output register feeding the ALU
//   fetch side:  in_valid/in_ready, in_pc, in_instr
//   reg file:    rs1_addr/rs2_addr out (combinational), rs1_data/rs2_data in (same cycle)
//   forwarding:  fwd_valid, fwd_rd, fwd_data (used only when DECODE_FWD_EN is defined)
//   control:     flush (highest priority), rst (async, active-high)
//   execute:     out_valid/out_ready, out_aluop, out_operand_1/2, out_rd, out_wen, out_illegal
module decode_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_aluop,
  output logic [31:0] out_operand_1,
  output logic [31:0] out_operand_2,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        out_illegal
);
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, rs1_val, rs2_val, dec_op1, dec_op2;
  logic [3:0]  dec_aluop;
  logic        legal, accept;
  assign opcode   = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];
  imm_gen u_imm_gen (.upper(in_instr[31:12]), .imm_i(imm_i), .imm_u(imm_u));
`ifdef DECODE_FWD_EN
  assign rs1_val = rs1_addr == 5'd0 ? '0 : (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs1_addr) ? fwd_data : rs1_data;
  assign rs2_val = rs2_addr == 5'd0 ? '0 : (fwd_valid && fwd_rd != 5'd0 && fwd_rd == rs2_addr) ? fwd_data : rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
  assign rs1_val = rs1_addr == 5'd0 ? '0 : rs1_data;
  assign rs2_val = rs2_addr == 5'd0 ? '0 : rs2_data;
`endif
  always_comb begin
    legal     = 1'b1;
    dec_aluop = f3_aluop(f3);
    dec_op1   = rs1_val;
    dec_op2   = rs2_val;
    case (opcode)
      OPC_OP: begin
        legal     = f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        dec_aluop = f7 == F7_ALT ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : f3_aluop(f3);
      end
      OPC_OP_IMM: begin
        legal     = f3 == 3'b001 ? f7 == F7_ZERO : f3 == 3'b101 ? (f7 == F7_ZERO || f7 == F7_ALT) : 1'b1;
        dec_aluop = (f3 == 3'b101 && f7 == F7_ALT) ? ALU_SRA : f3_aluop(f3);
        dec_op2   = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_instr[24:20]} : imm_i;
      end
      OPC_LUI: begin
        dec_aluop = ALU_ADD;
        dec_op1   = '0;
        dec_op2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_aluop = ALU_ADD;
        dec_op1   = in_pc;
        dec_op2   = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec_aluop = ALU_ADD;
      dec_op1   = '0;
      dec_op2   = '0;
    end
  end
  assign in_ready = !out_valid || out_ready || flush;
  assign accept   = in_valid && in_ready && !flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid     <= 1'b0;
      out_aluop     <= '0;
      out_operand_1 <= '0;
      out_operand_2 <= '0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_aluop     <= dec_aluop;
      out_operand_1 <= dec_op1;
      out_operand_2 <= dec_op2;
      out_rd        <= in_instr[11:7];
      out_wen       <= legal && in_instr[11:7] != 5'd0;
      out_illegal   <= !legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage against a spec-level reference model
module tb_decode_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, out_wen, out_illegal, fwd_valid = 0;
  logic [31:0] in_pc = 0, in_instr = 0, rs1_data = 0, rs2_data = 0, fwd_data = 0, out_operand_1, out_operand_2;
  logic [4:0]  rs1_addr, rs2_addr, fwd_rd = 0, out_rd;
  logic [3:0]  out_aluop;
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0]  aluop;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        wen, illegal;
  } exp_t;
  exp_t q[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2), .out_rd(out_rd),
    .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_read(input logic [4:0] a, input logic [31:0] d,
                                           input logic fv, input logic [4:0] frd, input logic [31:0] fd);
    if (a == 0) return 0;
`ifdef DECODE_FWD_EN
    if (fv && frd == a) return fd;
`endif
    return d;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] pc, ins, d1, d2,
                                     input logic fv, input logic [4:0] frd, input logic [31:0] fd);
    exp_t e;
    int base[8] = '{0, 5, 8, 9, 2, 6, 3, 4};
    logic [6:0]  f7 = ins[31:25];
    logic [2:0]  f3 = ins[14:12];
    logic [31:0] a = reg_read(ins[19:15], d1, fv, frd, fd);
    logic [31:0] b = reg_read(ins[24:20], d2, fv, frd, fd);
    logic [31:0] immi = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] immu = {ins[31:12], 12'h000};
    logic ok = 0;
    e = '{aluop: 0, op1: 0, op2: 0, rd: ins[11:7], wen: 0, illegal: 1};
    if (ins[6:0] == 7'h33) begin
      if (f7 == 0) begin ok = 1; e.aluop = 4'(base[f3]); end
      else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.aluop = 1; end
      else if (f7 == 7'h20 && f3 == 5) begin ok = 1; e.aluop = 7; end
      if (ok) begin e.op1 = a; e.op2 = b; end
    end else if (ins[6:0] == 7'h13) begin
      if (f3 == 1) ok = f7 == 0;
      else if (f3 == 5) ok = f7 == 0 || f7 == 7'h20;
      else ok = 1;
      if (ok) begin
        e.aluop = (f3 == 5 && f7 == 7'h20) ? 4'd7 : 4'(base[f3]);
        e.op1 = a;
        e.op2 = (f3 == 1 || f3 == 5) ? {27'd0, ins[24:20]} : immi;
      end
    end else if (ins[6:0] == 7'h37) begin
      ok = 1; e.op2 = immu;
    end else if (ins[6:0] == 7'h17) begin
      ok = 1; e.op1 = pc; e.op2 = immu;
    end
    e.illegal = !ok;
    e.wen = ok && ins[11:7] != 0;
    return e;
  endfunction

  always @(negedge clk) if (!rst) begin
    logic exp_ready;
    exp_ready = q.size() == 0 || out_ready || flush;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (out_valid && q.size() != 0) begin
      chk("aluop", {28'd0, out_aluop}, {28'd0, q[0].aluop});
      chk("operand_1", out_operand_1, q[0].op1);
      chk("operand_2", out_operand_2, q[0].op2);
      chk("rd", {27'd0, out_rd}, {27'd0, q[0].rd});
      chk("wen", {31'd0, out_wen}, {31'd0, q[0].wen});
      chk("illegal", {31'd0, out_illegal}, {31'd0, q[0].illegal});
    end
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(ref_model(in_pc, in_instr, rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data));
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, pc, d1, d2,
                       input logic ordy, fl, fv, input logic [4:0] frd, input logic [31:0] fd);
    in_valid = v; in_instr = ins; in_pc = pc; rs1_data = d1; rs2_data = d2;
    out_ready = ordy; flush = fl; fwd_valid = fv; fwd_rd = frd; fwd_data = fd;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    drive(0, 0, 0, 0, 0, ordy, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] r, ins;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_bundle", {out_aluop, out_rd, out_wen, out_illegal, 21'd0}, 0);
    chk("rst_op1", out_operand_1, 0);
    chk("rst_op2", out_operand_2, 0);
    rst = 0;
    @(posedge clk); #1;
    drive(1, 32'h002081B3, 32'h100, 5, 7, 1, 0, 0, 0, 0);
    drive(1, 32'hFFF00293, 32'h104, 32'h1234, 0, 1, 0, 0, 0, 0);
    drive(1, 32'h4043D313, 32'h108, 32'h80000000, 0, 1, 0, 0, 0, 0);
    drive(1, 32'h00000000, 32'h10C, 9, 9, 1, 0, 0, 0, 0);
    idle(1);
    drive(1, 32'h002081B3, 32'h200, 11, 22, 1, 0, 0, 0, 0);
    drive(1, 32'h40208233, 32'h204, 50, 8, 0, 0, 0, 0, 0);
    drive(1, 32'h40208233, 32'h204, 50, 8, 0, 0, 0, 0, 0);
    drive(1, 32'h40208233, 32'h204, 50, 8, 1, 0, 0, 0, 0);
    idle(1);
    drive(1, 32'h12345037, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    drive(1, 32'h00100093, 32'h400, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'hABCDE097, 32'h404, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    drive(1, 32'h002081B3, 32'h500, 5, 7, 1, 0, 1, 1, 32'h100);
    drive(1, 32'h002081B3, 32'h504, 5, 7, 1, 0, 1, 0, 32'h100);
    drive(1, 32'h002081B3, 32'h508, 5, 7, 1, 0, 1, 2, 32'h200);
    idle(1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      ins = $urandom;
      case ($urandom_range(0, 5))
        0, 1: ins[6:0] = 7'h33;
        2: ins[6:0] = 7'h13;
        3: ins[6:0] = 7'h37;
        4: ins[6:0] = 7'h17;
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      if (r[0]) begin
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      drive(r[3:1] != 0, ins, $urandom, $urandom, $urandom, r[6:4] != 0, r[11:7] == 0,
            r[12], 5'($urandom_range(0, 3)), $urandom);
    end
    idle(1);
    drive(1, 32'h002081B3, 32'h600, 3, 4, 1, 0, 0, 0, 0);
    idle(0);
    #1 rst = 1;
    #1;
    chk("midstall_rst_valid", {31'd0, out_valid}, 0);
    chk("midstall_rst_rd", {27'd0, out_rd}, 0);
    q.delete();
    #1 rst = 0;
    @(posedge clk); #1;
    drive(1, 32'h0FF3C393, 32'h700, 32'h0F0F0F0F, 0, 1, 0, 0, 0, 0);
    idle(1);
    idle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
